dds_channel: RTL and testbench
==============================

# dds_channel

Single-channel direct digital synthesis (DDS) core that produces 14-bit offset-binary samples for one DAC channel. Two instances run side by side on the 125 MHz sample clock, one feeding each DAC channel-data input of the DAC interface. Each instance runs a 32-bit phase accumulator and generates sine (from an external quarter-free full-wave ROM), square, triangle or sawtooth, with amplitude scaling. It accepts glitch-free runtime reconfiguration through a valid/ready handshake.

## Interface
Parameters:
- PHASE_W, 32, phase accumulator width
- ROM_AW, 10, sine ROM address width
- LATENCY, 3, accumulator-to-output pipeline depth (fixed; informational)

Ports:
- clk  in  1  125 MHz sample clock, same clock as the DAC interface
- rst  in  1  asynchronous, active-high reset
- en  in  1  1 = run, 0 = freeze phase and output midscale
- cfg_valid  in  1  new configuration offered
- cfg_ready  out  1  configuration slot free
- cfg_freq  in  32  frequency tuning word
- cfg_wave  in  2  0 sine, 1 square, 2 triangle, 3 sawtooth
- cfg_amp  in  9  gain, 256 = unity; values >256 clamp to 256
- cfg_phase_rst  in  1  clear accumulator when config is applied
- rom_addr  out  10  sine ROM address = acc[31:22], combinational from acc register
- rom_data  in  14  sine ROM data, offset binary, valid one cycle after rom_addr
- dac_data  out  14  sample to DAC interface, offset binary
- sync  out  1  one-cycle pulse aligned with the sample of phase 0-crossing

## Operation
- Accumulator: when en=1, acc <= acc + freq each cycle, modulo 2^32; a wrap is a carry-out of that add.
- Phase index p = acc[31:18] (14 bits). It is carried down the pipeline with wave and amp so that all three stay aligned.
- Waveform (stage 2):
  - sine: rom_data.
  - square: p[13] ? 0 : 16383.
  - triangle: p[13]=0 -> {p[12:0],0}; else ~{p[12:0],0}.
  - sawtooth: p.
- Scaling (stage 3):
  - s = sample with MSB inverted (signed 14-bit).
  - r = (s*amp) >>> 8, arithmetic, 23-bit product.
  - dac_data = r with MSB inverted.
  - No overflow is possible because amp is at most 256.
- Config handshake:
  - Transfer happens on cfg_valid & cfg_ready. The accepted set goes to a pending register and cfg_ready drops.
  - The pending set is applied in the cycle the accumulator wraps, or in the first cycle with en=0, whichever comes first. cfg_ready rises the cycle after it is applied.
  - Apply with cfg_phase_rst=1: acc <= 0 in that cycle instead of acc + freq.
  - While a set is pending, a second cfg_valid is held off (no overwrite).
- en=0:
  - acc holds its value.
  - The pipeline drives a midscale flag, so dac_data = 8192 from the 3rd cycle after en falls.
  - sync = 0.
  - On re-enable, samples resume from the held phase.
- sync: asserted with the dac_data sample whose accumulator cycle produced a wrap.

## Timing
- Reset values:
  - acc = 0, freq = 0, wave = 0, amp = 0.
  - dac_data = 8192, sync = 0, cfg_ready = 1.
  - Pending register is empty.
  - rom_addr = 0 as a consequence of acc = 0.
- Latency: the acc value held in cycle t appears on dac_data in cycle t+3. Stage timing is:
  - cycle t: acc register drives rom_addr.
  - cycle t+1: ROM output is available.
  - cycle t+2: waveform register.
  - cycle t+3: scaled output register.
- A config applied on a wrap affects the sample of the post-wrap acc value. That sample and every later one use the new freq, wave and amp; no earlier sample mixes settings.
- Reset mid-operation discards any pending config and returns all outputs to their reset values immediately (asynchronous).
- cfg_valid in the same cycle a pending set is applied is not accepted, because cfg_ready is still 0; it is accepted one cycle later.
- freq = 0 means the phase never wraps. A pending set is then applied only when en=0.

## Test plan
- Reset: assert rst mid-run with a pending config -> dac_data = 8192, sync = 0, cfg_ready = 1 in the same cycle; after release, output stays 8192 with amp = 0.
- Sawtooth: cfg_freq = 2^28, wave 3, amp 256, phase_rst, en = 1 -> dac_data steps 0, 1024, ..., 15360 and repeats every 16 cycles; sync pulses on every 0 sample.
- Amplitude: same as above with amp 128 -> sample 0 gives 4096 and sample 15360 gives 11776; amp 300 -> identical to amp 256.
- Square/triangle: freq 2^28, wave 1 -> 8 samples of 16383 then 8 of 0; wave 2 -> 0, 2048, ..., 14336, 16383, 14335, ..., 2047.
- Deferred update: while running at 2^28, offer freq 2^27 mid-period -> cfg_ready = 0 until the wrap, the step changes exactly at the post-wrap sample, and cfg_ready = 1 on the following cycle.
- Enable: drop en -> dac_data = 8192 three cycles later and acc is frozen; raise en -> sequence resumes from the held phase; sine mode reads the ROM model at rom_addr with 1-cycle latency and the output matches the model with 3-cycle latency.

Source files
------------

// File: rtl/dds_channel.sv
// Single-channel DDS: 32-bit phase accumulator, sine/square/triangle/saw
// generation with amplitude scaling, and deferred glitch-free reconfiguration.
module dds_channel #(
  parameter int unsigned PHASE_W = 32,
  parameter int unsigned ROM_AW  = 10,
  parameter int unsigned LATENCY = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [PHASE_W-1:0] cfg_freq,
  input  logic [1:0]         cfg_wave,
  input  logic [8:0]         cfg_amp,
  input  logic               cfg_phase_rst,
  output logic [ROM_AW-1:0]  rom_addr,
  input  logic [13:0]        rom_data,
  output logic [13:0]        dac_data,
  output logic               sync
);

  localparam int unsigned SMP_W = 14;
  localparam int unsigned AMP_W = 9;
  localparam logic [SMP_W-1:0] MIDSCALE = 14'd8192;
  localparam logic [AMP_W-1:0] AMP_MAX  = 9'd256;

  // Active configuration and accumulator
  logic [PHASE_W-1:0] acc_q, acc_d, freq_q, freq_d;
  logic [1:0]         wave_q, wave_d;
  logic [AMP_W-1:0]   amp_q, amp_d;
  logic               wrap_q, wrap_d;

  // Pending configuration slot
  logic               pend_q, pend_d, ready_q, ready_d;
  logic [PHASE_W-1:0] pfreq_q, pfreq_d;
  logic [1:0]         pwave_q, pwave_d;
  logic [AMP_W-1:0]   pamp_q, pamp_d;
  logic               pprst_q, pprst_d;

  // Pipeline stages
  logic [SMP_W-1:0]   p1_q, p1_d, smp2_q, smp2_d, dac_q, dac_d;
  logic [1:0]         wave1_q, wave1_d;
  logic [AMP_W-1:0]   amp1_q, amp1_d, amp2_q, amp2_d;
  logic               mid1_q, mid1_d, mid2_q, mid2_d;
  logic [LATENCY-1:0] sync_sr_q, sync_sr_d;

  logic [PHASE_W:0]   sum;
  logic               carry, apply;
  logic signed [SMP_W-1:0] s_val;
  logic signed [AMP_W:0]   a_val;
  logic signed [23:0]      prod;
  logic                    unused_prod;

  assign sum   = {1'b0, acc_q} + {1'b0, freq_q};
  assign carry = sum[PHASE_W];
  // Pending set lands on a wrap, or immediately while stopped
  assign apply = pend_q & (~en | carry);

  always_comb begin
    acc_d   = acc_q;
    freq_d  = freq_q;
    wave_d  = wave_q;
    amp_d   = amp_q;
    wrap_d  = en & carry;
    pend_d  = pend_q;
    pfreq_d = pfreq_q;
    pwave_d = pwave_q;
    pamp_d  = pamp_q;
    pprst_d = pprst_q;
    if (en) acc_d = sum[PHASE_W-1:0];
    if (apply) begin
      freq_d = pfreq_q;
      wave_d = pwave_q;
      amp_d  = pamp_q;
      pend_d = 1'b0;
      if (pprst_q) acc_d = '0;
    end else if (cfg_valid && ready_q) begin
      pend_d  = 1'b1;
      pfreq_d = cfg_freq;
      pwave_d = cfg_wave;
      pamp_d  = (cfg_amp > AMP_MAX) ? AMP_MAX : cfg_amp;
      pprst_d = cfg_phase_rst;
    end
    ready_d = ~pend_d;
  end

  // Stage 1 carries phase, wave and amp alongside the ROM lookup
  assign p1_d    = acc_q[PHASE_W-1 -: SMP_W];
  assign wave1_d = wave_q;
  assign amp1_d  = amp_q;
  assign mid1_d  = ~en;
  assign sync_sr_d = {sync_sr_q[LATENCY-2:0], wrap_q & en};

  always_comb begin
    smp2_d = p1_q;
    case (wave1_q)
      2'd0:    smp2_d = rom_data;
      2'd1:    smp2_d = p1_q[SMP_W-1] ? '0 : '1;
      2'd2:    smp2_d = p1_q[SMP_W-1] ? ~{p1_q[SMP_W-2:0], 1'b0} : {p1_q[SMP_W-2:0], 1'b0};
      default: smp2_d = p1_q;
    endcase
  end
  assign amp2_d = amp1_q;
  assign mid2_d = mid1_q;

  // Scale in signed domain; amp <= 256 keeps the result in range
  assign s_val = {~smp2_q[SMP_W-1], smp2_q[SMP_W-2:0]};
  assign a_val = {1'b0, amp2_q};
  assign prod  = 24'(s_val) * 24'(a_val);
  assign dac_d = mid2_q ? MIDSCALE : {~prod[21], prod[20:8]};
  assign unused_prod = ^{prod[23:22], prod[7:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      freq_q    <= '0;
      wave_q    <= '0;
      amp_q     <= '0;
      wrap_q    <= 1'b0;
      pend_q    <= 1'b0;
      ready_q   <= 1'b1;
      pfreq_q   <= '0;
      pwave_q   <= '0;
      pamp_q    <= '0;
      pprst_q   <= 1'b0;
      p1_q      <= '0;
      wave1_q   <= '0;
      amp1_q    <= '0;
      mid1_q    <= 1'b1;
      smp2_q    <= '0;
      amp2_q    <= '0;
      mid2_q    <= 1'b1;
      dac_q     <= MIDSCALE;
      sync_sr_q <= '0;
    end else begin
      acc_q     <= acc_d;
      freq_q    <= freq_d;
      wave_q    <= wave_d;
      amp_q     <= amp_d;
      wrap_q    <= wrap_d;
      pend_q    <= pend_d;
      ready_q   <= ready_d;
      pfreq_q   <= pfreq_d;
      pwave_q   <= pwave_d;
      pamp_q    <= pamp_d;
      pprst_q   <= pprst_d;
      p1_q      <= p1_d;
      wave1_q   <= wave1_d;
      amp1_q    <= amp1_d;
      mid1_q    <= mid1_d;
      smp2_q    <= smp2_d;
      amp2_q    <= amp2_d;
      mid2_q    <= mid2_d;
      dac_q     <= dac_d;
      sync_sr_q <= sync_sr_d;
    end
  end

  assign rom_addr  = acc_q[PHASE_W-1 -: ROM_AW];
  assign cfg_ready = ready_q;
  assign dac_data  = dac_q;
  assign sync      = sync_sr_q[LATENCY-1];

endmodule

// File: tb/tb_dds_channel.sv
// Randomized bench for dds_channel against a per-cycle arithmetic model of
// phase, configuration hand-off and waveform/amplitude rules.
module tb_dds_channel;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_freq;
  logic [1:0]  cfg_wave;
  logic [8:0]  cfg_amp;
  logic        cfg_phase_rst;
  logic [9:0]  rom_addr;
  logic [13:0] rom_data;
  logic [13:0] dac_data;
  logic        sync;

  int n_checks = 0;
  int n_errors = 0;

  dds_channel #(.PHASE_W(32), .ROM_AW(10), .LATENCY(3)) dut (
    .clk(clk), .rst(rst), .en(en),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_freq(cfg_freq),
    .cfg_wave(cfg_wave), .cfg_amp(cfg_amp), .cfg_phase_rst(cfg_phase_rst),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .dac_data(dac_data), .sync(sync)
  );

  always #4 clk = ~clk;

  function automatic logic [13:0] rom_fn(input logic [9:0] a);
    real x;
    x = 8191.5 + 8191.0 * $sin(6.283185307179586 * real'(int'(a)) / 1024.0);
    return 14'($rtoi(x));
  endfunction

  // Synchronous sine ROM: data one cycle after the address
  always @(posedge clk) rom_data <= rom_fn(rom_addr);

  // Reference model state
  int unsigned m_acc, m_freq, p_freq;
  int          m_wave, m_amp, p_wave, p_amp;
  bit          m_pend, m_wrapped, p_prst;
  int          exp_dac[$];
  int          exp_sync[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_acc = 0; m_freq = 0; m_wave = 0; m_amp = 0;
    m_pend = 0; m_wrapped = 0;
    p_freq = 0; p_wave = 0; p_amp = 0; p_prst = 0;
    exp_dac = {8192, 8192, 8192};
    exp_sync = {0, 0, 0};
  endtask

  function automatic int model_sample(input bit e);
    int p, smp, a;
    if (!e) return 8192;
    p = int'(m_acc >> 18);
    case (m_wave)
      0:       smp = int'(rom_fn(10'(m_acc >> 22)));
      1:       smp = (p >= 8192) ? 0 : 16383;
      2:       smp = (p < 8192) ? 2 * p : 16383 - 2 * (p - 8192);
      default: smp = p;
    endcase
    a = (m_amp > 256) ? 256 : m_amp;
    return (((smp - 8192) * a) >>> 8) + 8192;
  endfunction

  task automatic model_advance(input bit e, input bit v, input logic [31:0] f,
                               input logic [1:0] w, input logic [8:0] a, input bit pr);
    longint unsigned tot;
    bit carry, apply;
    tot   = longint'(m_acc) + longint'(m_freq);
    carry = e && (tot >= 64'h1_0000_0000);
    apply = m_pend && (!e || carry);
    m_wrapped = carry;
    if (e) m_acc = 32'(tot);
    if (apply) begin
      m_freq = p_freq; m_wave = p_wave; m_amp = p_amp;
      if (p_prst) m_acc = 0;
      m_pend = 0;
    end else if (v && !m_pend) begin
      p_freq = f; p_wave = int'(w); p_amp = int'(a); p_prst = pr;
      m_pend = 1;
    end
  endtask

  // One sample cycle: check outputs, drive inputs, advance the model
  task automatic step(input bit e, input bit v, input logic [31:0] f,
                      input logic [1:0] w, input logic [8:0] a, input bit pr);
    int d, s;
    @(negedge clk);
    d = exp_dac.pop_front();
    s = exp_sync.pop_front();
    check("dac_data", 32'(dac_data), 32'(d));
    check("sync", 32'(sync), 32'(s));
    check("cfg_ready", 32'(cfg_ready), 32'(!m_pend));
    check("rom_addr", 32'(rom_addr), m_acc >> 22);
    en = e; cfg_valid = v; cfg_freq = f; cfg_wave = w; cfg_amp = a; cfg_phase_rst = pr;
    exp_dac.push_back(model_sample(e));
    exp_sync.push_back((e && m_wrapped) ? 1 : 0);
    model_advance(e, v, f, w, a, pr);
  endtask

  task automatic run(input int n, input bit e);
    for (int i = 0; i < n; i++) step(e, 1'b0, 32'h0, 2'd0, 9'd0, 1'b0);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  initial begin
    bit          re;
    int          sel;
    logic [31:0] rf;
    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_freq = '0;
    cfg_wave = '0; cfg_amp = '0; cfg_phase_rst = 1'b0;
    repeat (3) @(negedge clk);
    release_reset();
    run(3, 1'b0);
    run(5, 1'b1);

    // Sawtooth, then amplitude 128 and clamped 300
    step(1'b0, 1'b1, 32'h1000_0000, 2'd3, 9'd256, 1'b1);
    run(2, 1'b0);
    run(40, 1'b1);
    step(1'b1, 1'b1, 32'h1000_0000, 2'd3, 9'd128, 1'b0);
    run(40, 1'b1);
    step(1'b1, 1'b1, 32'h1000_0000, 2'd3, 9'd300, 1'b0);
    run(40, 1'b1);
    // Square and triangle
    step(1'b1, 1'b1, 32'h1000_0000, 2'd1, 9'd256, 1'b0);
    run(40, 1'b1);
    step(1'b1, 1'b1, 32'h1000_0000, 2'd2, 9'd256, 1'b0);
    run(40, 1'b1);
    // Deferred frequency change mid-period
    step(1'b1, 1'b1, 32'h1000_0000, 2'd3, 9'd256, 1'b0);
    run(25, 1'b1);
    step(1'b1, 1'b1, 32'h0800_0000, 2'd3, 9'd256, 1'b0);
    run(40, 1'b1);
    // Enable gating
    run(6, 1'b0);
    run(20, 1'b1);
    run(1, 1'b0);
    run(3, 1'b1);
    run(2, 1'b0);
    run(10, 1'b1);
    // Sine through the ROM
    step(1'b1, 1'b1, 32'h0123_4567, 2'd0, 9'd256, 1'b1);
    run(100, 1'b1);
    run(5, 1'b0);
    run(50, 1'b1);
    step(1'b1, 1'b1, 32'h0765_4321, 2'd0, 9'd77, 1'b0);
    run(60, 1'b1);
    // freq 0: pending set waits for en=0
    step(1'b1, 1'b1, 32'h0, 2'd3, 9'd256, 1'b0);
    run(30, 1'b1);
    step(1'b1, 1'b1, 32'h1000_0000, 2'd2, 9'd200, 1'b0);
    run(10, 1'b1);
    run(2, 1'b0);
    run(20, 1'b1);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      re  = ($urandom_range(0, 15) != 0);
      sel = $urandom_range(0, 3);
      case (sel)
        0:       rf = $urandom;
        1:       rf = 32'h1000_0000;
        2:       rf = 32'($urandom_range(0, 255));
        default: rf = 32'h2000_0000 | ($urandom & 32'h1FFF_FFFF);
      endcase
      step(re, ($urandom_range(0, 7) == 0), rf, 2'($urandom_range(0, 3)),
           9'($urandom_range(0, 319)), 1'($urandom_range(0, 1)));
    end

    // Reset mid-run with a pending config
    step(1'b0, 1'b1, 32'h0000_0100, 2'd3, 9'd256, 1'b1);
    run(2, 1'b0);
    run(5, 1'b1);
    step(1'b1, 1'b1, 32'h1000_0000, 2'd1, 9'd100, 1'b1);
    run(3, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_dac_data", 32'(dac_data), 32'd8192);
    check("rst_sync", 32'(sync), 32'd0);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    repeat (2) @(negedge clk);
    release_reset();
    run(5, 1'b0);
    run(10, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
